// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC, IF/ID register and one-entry hold buffer for stalled fetches.
// Optional IF_FLUSH_EN discards the delay-slot word on a taken jump or branch.
module fetch_unit (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        stall_b,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        branch,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid,
    output logic        halted
);
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] hold_data;
    logic [31:0] redirect_target;
    logic [31:0] load_data;
    logic        redirect;
    logic        flush;
    logic        go_halt;
    logic        load_word;
    logic        load_bubble;
    logic        capture_hold;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign redirect  = jump | (branch & branch_taken);
    assign redirect_target = jump ? {if_pc_plus4[31:28], jump_index, 2'b00}
                                  : if_pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};

`ifdef IF_FLUSH_EN
    assign flush = redirect;
`else
    assign flush = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (stall_b && halt) begin
                    state_next = HALT;
                end else if (!stall_b && imem_ready) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (stall_b) begin
                    state_next = halt ? HALT : FETCH;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // imem_req is gated by rst_b so it stays low for the whole reset pulse
    always_comb begin
        imem_req     = 1'b0;
        go_halt      = 1'b0;
        load_word    = 1'b0;
        load_bubble  = 1'b0;
        capture_hold = 1'b0;
        load_data    = imem_rdata;
        case (state)
            FETCH: begin
                imem_req = rst_b;
                if (stall_b) begin
                    if (halt) begin
                        go_halt = 1'b1;
                    end else if (imem_ready) begin
                        load_word = 1'b1;
                    end else begin
                        load_bubble = 1'b1;
                    end
                end else begin
                    capture_hold = imem_ready;
                end
            end
            HOLD: begin
                load_data = hold_data;
                if (stall_b) begin
                    go_halt   = halt;
                    load_word = ~halt;
                end
            end
            default: ;
        endcase
    end

    // A redirect during a memory bubble still updates PC so the jump is not lost
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pc          <= 32'd0;
            instruction <= 32'd0;
            if_pc_plus4 <= 32'd0;
            if_valid    <= 1'b0;
            halted      <= 1'b0;
            hold_data   <= 32'd0;
        end else begin
            if (capture_hold) begin
                hold_data <= imem_rdata;
            end
            if (go_halt) begin
                halted      <= 1'b1;
                instruction <= 32'd0;
                if_valid    <= 1'b0;
            end else if (load_word) begin
                instruction <= flush ? 32'd0 : load_data;
                if_valid    <= ~flush;
                if_pc_plus4 <= pc_plus4;
                pc          <= redirect ? redirect_target : pc_plus4;
            end else if (load_bubble) begin
                instruction <= 32'd0;
                if_valid    <= 1'b0;
                if (redirect) begin
                    pc <= redirect_target;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a behavioural IF-stage model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_b;
    logic        stall_b;
    logic        jump;
    logic [25:0] jump_index;
    logic        branch;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        halt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] if_pc_plus4;
    logic        if_valid;
    logic        halted;

    int total = 0;
    int bad   = 0;

`ifdef IF_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    localparam int M_FETCH = 0;
    localparam int M_HOLD  = 1;
    localparam int M_HALT  = 2;

    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic [31:0] m_hold;
    logic        m_valid;
    logic        m_halted;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst_b(rst_b), .stall_b(stall_b), .jump(jump), .jump_index(jump_index),
        .branch(branch), .branch_taken(branch_taken), .branch_imm(branch_imm), .halt(halt),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .instruction(instruction), .if_pc_plus4(if_pc_plus4),
        .if_valid(if_valid), .halted(halted)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    always_comb imem_rdata = mem_word(imem_addr);

    task automatic model_reset();
        m_mode = M_FETCH; m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0;
        m_hold = 32'd0; m_valid = 1'b0; m_halted = 1'b0;
    endtask

    // One rising edge of the IF stage, written from the stage's rules rather than its logic
    task automatic model_step();
        logic               taken;
        logic               have;
        logic [31:0]        nxt;
        logic [31:0]        word;
        logic signed [31:0] off;
        if (m_mode == M_HALT) return;
        if (!stall_b) begin
            if (m_mode == M_FETCH && imem_ready) begin
                m_hold = mem_word(m_pc);
                m_mode = M_HOLD;
            end
            return;
        end
        if (halt) begin
            m_mode = M_HALT; m_halted = 1'b1; m_instr = 32'd0; m_valid = 1'b0;
            return;
        end
        taken = jump || (branch && branch_taken);
        off   = $signed(branch_imm) * 4;
        nxt   = jump ? {m_pc4[31:28], jump_index, 2'b00} : (taken ? m_pc4 + off : m_pc + 32'd4);
        have  = (m_mode == M_HOLD) || imem_ready;
        word  = (m_mode == M_HOLD) ? m_hold : mem_word(m_pc);
        if (have) begin
            if (taken && FLUSH) begin
                m_instr = 32'd0; m_valid = 1'b0;
            end else begin
                m_instr = word; m_valid = 1'b1;
            end
            m_pc4 = m_pc + 32'd4;
            m_pc  = nxt;
        end else begin
            m_instr = 32'd0; m_valid = 1'b0;
            if (taken) m_pc = nxt;
        end
        m_mode = M_FETCH;
    endtask

    task automatic idle_inputs();
        stall_b = 1'b1; imem_ready = 1'b1; jump = 1'b0; jump_index = 26'd0;
        branch = 1'b0; branch_taken = 1'b0; branch_imm = 16'd0; halt = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_b = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_b = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic cycle(input logic st, input logic rdy, input logic j, input logic br,
                         input logic bt, input logic h, input logic [25:0] ji,
                         input logic [15:0] bi);
        stall_b = st; imem_ready = rdy; jump = j; branch = br; branch_taken = bt;
        halt = h; jump_index = ji; branch_imm = bi;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        idle_inputs();
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", imem_req); end
        total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL rst_addr got=%h want=0", imem_addr); end
        total++; if (instruction !== 32'd0) begin bad++; $display("FAIL rst_instr got=%h want=0", instruction); end
        total++; if (if_pc_plus4 !== 32'd0) begin bad++; $display("FAIL rst_pc4 got=%h want=0", if_pc_plus4); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", if_valid); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b want=0", halted); end
        @(negedge clk);
        rst_b = 1'b1;
        model_reset();
        #1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_first_req got=%b want=1", imem_req); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr;
        do_reset();
        total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL seq_first_addr got=%h want=0", imem_addr); end
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 0, 0, 0, 26'd0, 16'd0);
            exp_addr = 32'(4 * (i + 1));
            total++; if (imem_addr !== exp_addr) begin bad++; $display("FAIL seq_addr got=%h want=%h", imem_addr, exp_addr); end
            total++; if (instruction !== mem_word(32'(4 * i))) begin bad++; $display("FAIL seq_instr got=%h want=%h", instruction, mem_word(32'(4 * i))); end
            total++; if (if_pc_plus4 !== exp_addr) begin bad++; $display("FAIL seq_pc4 got=%h want=%h", if_pc_plus4, exp_addr); end
            total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL seq_valid got=%b want=1", if_valid); end
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        repeat (2) cycle(1, 1, 0, 0, 0, 0, 26'd0, 16'd0);
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 0, 0, 0, 0, 26'd0, 16'd0);
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL hold_req got=%b want=0", imem_req); end
            total++; if (imem_addr !== 32'd8) begin bad++; $display("FAIL hold_addr got=%h want=8", imem_addr); end
            total++; if (instruction !== mem_word(32'd4)) begin bad++; $display("FAIL hold_instr got=%h want=%h", instruction, mem_word(32'd4)); end
            total++; if (if_pc_plus4 !== 32'd8) begin bad++; $display("FAIL hold_pc4 got=%h want=8", if_pc_plus4); end
        end
        cycle(1, 0, 0, 0, 0, 0, 26'd0, 16'd0);
        total++; if (instruction !== mem_word(32'd8)) begin bad++; $display("FAIL release_instr got=%h want=%h", instruction, mem_word(32'd8)); end
        total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL release_valid got=%b want=1", if_valid); end
        total++; if (if_pc_plus4 !== 32'd12) begin bad++; $display("FAIL release_pc4 got=%h want=c", if_pc_plus4); end
        total++; if (imem_addr !== 32'd12) begin bad++; $display("FAIL release_addr got=%h want=c", imem_addr); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL release_req got=%b want=1", imem_req); end
    endtask

    task automatic test_jump();
        do_reset();
        repeat (2) cycle(1, 1, 0, 0, 0, 0, 26'd0, 16'd0);
        cycle(1, 1, 1, 0, 0, 0, 26'h40, 16'd0);
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL jump_addr got=%h want=100", imem_addr); end
        total++; if (instruction !== (FLUSH ? 32'd0 : mem_word(32'd8))) begin bad++; $display("FAIL jump_slot_instr got=%h want=%h", instruction, FLUSH ? 32'd0 : mem_word(32'd8)); end
        total++; if (if_valid !== !FLUSH) begin bad++; $display("FAIL jump_slot_valid got=%b want=%b", if_valid, !FLUSH); end
        cycle(1, 1, 0, 0, 0, 0, 26'd0, 16'd0);
        total++; if (imem_addr !== 32'h104) begin bad++; $display("FAIL jump_next_addr got=%h want=104", imem_addr); end
        total++; if (instruction !== mem_word(32'h100)) begin bad++; $display("FAIL jump_target_instr got=%h want=%h", instruction, mem_word(32'h100)); end
        total++; if (if_pc_plus4 !== 32'h104) begin bad++; $display("FAIL jump_target_pc4 got=%h want=104", if_pc_plus4); end
    endtask

    task automatic test_branch();
        do_reset();
        repeat (4) cycle(1, 1, 0, 0, 0, 0, 26'd0, 16'd0);
        cycle(1, 1, 0, 1, 1, 0, 26'd0, 16'hFFFE);
        total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL br_taken_addr got=%h want=8", imem_addr); end
        cycle(1, 1, 0, 0, 0, 0, 26'd0, 16'd0);
        total++; if (instruction !== mem_word(32'h8)) begin bad++; $display("FAIL br_target_instr got=%h want=%h", instruction, mem_word(32'h8)); end
        total++; if (if_pc_plus4 !== 32'hC) begin bad++; $display("FAIL br_target_pc4 got=%h want=c", if_pc_plus4); end
        do_reset();
        repeat (4) cycle(1, 1, 0, 0, 0, 0, 26'd0, 16'd0);
        cycle(1, 1, 0, 1, 0, 0, 26'd0, 16'hFFFE);
        total++; if (imem_addr !== 32'h14) begin bad++; $display("FAIL br_not_taken_addr got=%h want=14", imem_addr); end
        total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL br_not_taken_valid got=%b want=1", if_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        cycle(1, 1, 0, 0, 0, 0, 26'd0, 16'd0);
        cycle(1, 1, 0, 1, 1, 0, 26'd0, 16'hFFFE);
        total++; if (imem_addr !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_branch_addr got=%h want=fffffffc", imem_addr); end
        cycle(1, 1, 0, 0, 0, 0, 26'd0, 16'd0);
        total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL wrap_addr got=%h want=0", imem_addr); end
        total++; if (if_pc_plus4 !== 32'd0) begin bad++; $display("FAIL wrap_pc4 got=%h want=0", if_pc_plus4); end
        total++; if (instruction !== mem_word(32'hFFFFFFFC)) begin bad++; $display("FAIL wrap_instr got=%h want=%h", instruction, mem_word(32'hFFFFFFFC)); end
    endtask

    task automatic test_bubbles();
        do_reset();
        cycle(1, 1, 0, 0, 0, 0, 26'd0, 16'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0, 0, 0, 26'd0, 16'd0);
            total++; if (instruction !== 32'd0) begin bad++; $display("FAIL bubble_instr got=%h want=0", instruction); end
            total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL bubble_valid got=%b want=0", if_valid); end
            total++; if (imem_addr !== 32'd4) begin bad++; $display("FAIL bubble_addr got=%h want=4", imem_addr); end
        end
        cycle(1, 1, 0, 0, 0, 0, 26'd0, 16'd0);
        total++; if (instruction !== mem_word(32'd4)) begin bad++; $display("FAIL bubble_end_instr got=%h want=%h", instruction, mem_word(32'd4)); end
        total++; if (imem_addr !== 32'd8) begin bad++; $display("FAIL bubble_end_addr got=%h want=8", imem_addr); end
    endtask

    task automatic test_halt();
        do_reset();
        repeat (2) cycle(1, 1, 0, 0, 0, 0, 26'd0, 16'd0);
        cycle(1, 1, 0, 0, 0, 1, 26'd0, 16'd0);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b want=1", halted); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL halt_req got=%b want=0", imem_req); end
        total++; if (instruction !== 32'd0) begin bad++; $display("FAIL halt_instr got=%h want=0", instruction); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL halt_valid got=%b want=0", if_valid); end
        for (int i = 0; i < 4; i++) begin
            cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 26'($urandom), 16'($urandom));
            total++; if (halted !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL halt_frozen got=%b/%b want=1/0", halted, imem_req); end
            total++; if (imem_addr !== 32'd8) begin bad++; $display("FAIL halt_addr got=%h want=8", imem_addr); end
            total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL halt_frozen_valid got=%b want=0", if_valid); end
        end
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_rst_flag got=%b want=0", halted); end
        total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL halt_rst_addr got=%h want=0", imem_addr); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL halt_rst_req got=%b want=0", imem_req); end
        idle_inputs();
        @(negedge clk);
        rst_b = 1'b1;
        model_reset();
        #1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL halt_restart_req got=%b want=1", imem_req); end
        cycle(1, 1, 0, 0, 0, 0, 26'd0, 16'd0);
        total++; if (instruction !== mem_word(32'd0)) begin bad++; $display("FAIL halt_restart_instr got=%h want=%h", instruction, mem_word(32'd0)); end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        cycle(1, 1, 0, 0, 0, 0, 26'd0, 16'd0);
        cycle(0, 1, 0, 0, 0, 0, 26'd0, 16'd0);
        #2;
        rst_b = 1'b0;
        #1;
        total++; if (instruction !== 32'd0 || if_valid !== 1'b0) begin bad++; $display("FAIL midhold_rst_ifid got=%h/%b want=0/0", instruction, if_valid); end
        total++; if (imem_addr !== 32'd0 || imem_req !== 1'b0) begin bad++; $display("FAIL midhold_rst_fetch got=%h/%b want=0/0", imem_addr, imem_req); end
        total++; if (if_pc_plus4 !== 32'd0) begin bad++; $display("FAIL midhold_rst_pc4 got=%h want=0", if_pc_plus4); end
        idle_inputs();
        @(negedge clk);
        rst_b = 1'b1;
        model_reset();
        #1;
        cycle(1, 1, 0, 0, 0, 0, 26'd0, 16'd0);
        total++; if (instruction !== mem_word(32'd0)) begin bad++; $display("FAIL midhold_after_instr got=%h want=%h", instruction, mem_word(32'd0)); end
        total++; if (imem_addr !== 32'd4) begin bad++; $display("FAIL midhold_after_addr got=%h want=4", imem_addr); end
    endtask

    task automatic test_random();
        logic st, rdy, can_redir, j, br, bt, h;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if ((m_mode == M_HALT && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                do_reset();
            end
            st  = ($urandom_range(0, 4) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            // redirects only when decode holds a real word and the fetch slot is filled
            can_redir = m_valid && st && (m_mode == M_HOLD || (m_mode == M_FETCH && rdy));
            j  = can_redir && ($urandom_range(0, 7) == 0);
            br = 1'($urandom);
            bt = can_redir && ($urandom_range(0, 3) == 0);
            h  = ($urandom_range(0, 149) == 0);
            cycle(st, rdy, j, br, bt, h, 26'($urandom), 16'($urandom));
            total++; if (imem_req !== (m_mode == M_FETCH)) begin bad++; $display("FAIL rnd_req got=%b want=%b", imem_req, m_mode == M_FETCH); end
            total++; if (imem_addr !== m_pc) begin bad++; $display("FAIL rnd_addr got=%h want=%h", imem_addr, m_pc); end
            total++; if (halted !== m_halted) begin bad++; $display("FAIL rnd_halted got=%b want=%b", halted, m_halted); end
            total++; if (if_valid !== m_valid) begin bad++; $display("FAIL rnd_valid got=%b want=%b", if_valid, m_valid); end
            total++; if (instruction !== m_instr) begin bad++; $display("FAIL rnd_instr got=%h want=%h", instruction, m_instr); end
            if (m_valid) begin
                total++; if (if_pc_plus4 !== m_pc4) begin bad++; $display("FAIL rnd_pc4 got=%h want=%h", if_pc_plus4, m_pc4); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_hold();
        test_jump();
        test_branch();
        test_wrap();
        test_bubbles();
        test_halt();
        test_reset_mid_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
